switch_conditioner: RTL and testbench

- Input front end of the anti-theft system.
- Takes the raw, asynchronous, bouncing brake, ignition and hidden-switch contacts and synchronises and debounces each one.
- Drives the clean `brk`, `ignition` and `hidden_sw` levels consumed by the fuel-pump and alarm FSMs.
- Also produces single-cycle ignition edge pulses and a `ready` flag, so downstream FSMs ignore the settle period after reset.

---
 rtl/switch_conditioner.sv | 121 ++++++++++++
 tb/tb_switch_conditioner.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/switch_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : switch_conditioner
// Description : Two-flop synchronisation and counter debounce for the brake,
//               ignition and hidden-switch contacts, plus ignition edge pulses,
//               an any-change pulse and a post-reset ready flag.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic brk_raw,
    input  logic ignition_raw,
    input  logic hidden_sw_raw,
    output logic brk,
    output logic ignition,
    output logic hidden_sw,
    output logic ignition_rise,
    output logic ignition_fall,
    output logic any_change,
    output logic ready
);

    localparam int               c_NUM_CH   = 3;
    localparam int               c_IGN_CH   = 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel order: [2] brake, [1] ignition, [0] hidden switch
    logic [c_NUM_CH-1:0] w_raw;
    logic [c_NUM_CH-1:0] w_sync;
    logic [c_NUM_CH-1:0] w_stable;
    logic [c_NUM_CH-1:0] w_update;

    assign w_raw = {brk_raw, ignition_raw, hidden_sw_raw};

    generate
        for (genvar i = 0; i < c_NUM_CH; i++) begin : g_chan
            logic             r_s1;
            logic             r_s2;
            logic             r_stable;
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_s1     <= 1'b0;
                    r_s2     <= 1'b0;
                    r_stable <= 1'b0;
                    r_cnt    <= '0;
                end else begin
                    r_s1 <= w_raw[i];
                    r_s2 <= r_s1;
                    // Any sample back at the stable level restarts the run
                    if (r_s2 == r_stable) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_stable <= r_s2;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_sync[i]   = r_s2;
            assign w_stable[i] = r_stable;
            assign w_update[i] = (r_s2 != r_stable) && (r_cnt == c_CNT_LAST);
        end
    endgenerate

    // Startup: counter reaches DEBOUNCE_CYCLES-1, then three more stages so that
    // ready rises on edge DEBOUNCE_CYCLES+3 without the counter needing extra width.
    logic [CNT_W-1:0] r_start_cnt;
    logic [2:0]       r_settle_sr;
    logic             r_ready;
    logic             w_start_done;

    assign w_start_done = (r_start_cnt == c_CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_start_cnt <= '0;
            r_settle_sr <= '0;
            r_ready     <= 1'b0;
        end else begin
            if (!w_start_done) begin
                r_start_cnt <= r_start_cnt + 1'b1;
            end
            r_settle_sr <= {r_settle_sr[1:0], w_start_done};
            r_ready     <= r_ready | r_settle_sr[2];
        end
    end

    logic r_ign_rise;
    logic r_ign_fall;
    logic r_any_change;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ign_rise   <= 1'b0;
            r_ign_fall   <= 1'b0;
            r_any_change <= 1'b0;
        end else begin
            r_ign_rise   <= r_ready & w_update[c_IGN_CH] &  w_sync[c_IGN_CH];
            r_ign_fall   <= r_ready & w_update[c_IGN_CH] & ~w_sync[c_IGN_CH];
            r_any_change <= r_ready & (|w_update);
        end
    end

    assign brk           = w_stable[2];
    assign ignition      = w_stable[1];
    assign hidden_sw     = w_stable[0];
    assign ignition_rise = r_ign_rise;
    assign ignition_fall = r_ign_fall;
    assign any_change    = r_any_change;
    assign ready         = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_switch_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_conditioner
// Description : Self-checking bench for switch_conditioner (DEBOUNCE_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_conditioner;

    localparam int D = 4;

    logic clock;
    logic reset;
    logic brk_raw, ignition_raw, hidden_sw_raw;
    logic brk, ignition, hidden_sw, ignition_rise, ignition_fall, any_change, ready;

    switch_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(5)) dut (
        .clock         (clock),
        .reset         (reset),
        .brk_raw       (brk_raw),
        .ignition_raw  (ignition_raw),
        .hidden_sw_raw (hidden_sw_raw),
        .brk           (brk),
        .ignition      (ignition),
        .hidden_sw     (hidden_sw),
        .ignition_rise (ignition_rise),
        .ignition_fall (ignition_fall),
        .any_change    (any_change),
        .ready         (ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: window model - a level changes when the last D compared samples
    // all differ from it; ready once D+3 edges have elapsed since reset.
    logic [2:0]   m_s1, m_s2, m_stable;
    logic [D-1:0] m_hist [3];
    int           m_edges;
    logic         m_ready;
    logic [6:0]   sb_q [$];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_edges = 0; m_ready = 1'b0;
        for (int c = 0; c < 3; c++) m_hist[c] = '0;
        sb_q.delete();
    endtask

    task automatic model_step(input logic [2:0] raw, output logic [6:0] exp);
        logic [2:0] upd;
        logic       rise, fall, anyc;
        for (int c = 0; c < 3; c++) begin
            m_hist[c] = {m_hist[c][D-2:0], m_s2[c]};
            upd[c]    = (m_hist[c] == {D{~m_stable[c]}});
        end
        rise = m_ready & upd[1] & ~m_stable[1];
        fall = m_ready & upd[1] &  m_stable[1];
        anyc = m_ready & (|upd);
        m_stable = m_stable ^ upd;
        m_edges++;
        m_ready = (m_edges >= D + 3);
        m_s2 = m_s1;
        m_s1 = raw;
        exp = {m_stable, m_ready, rise, fall, anyc};
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] dut_vec();
        return {brk, ignition, hidden_sw, ready, ignition_rise, ignition_fall, any_change};
    endfunction

    // One clock: drive raw inputs, push the expectation, compare after the edge
    task automatic cycle(input logic b, input logic i, input logic h);
        logic [6:0] exp;
        brk_raw = b; ignition_raw = i; hidden_sw_raw = h;
        model_step({b, i, h}, exp);
        sb_q.push_back(exp);
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            check("scoreboard", dut_vec(), sb_q.pop_front());
        end
    endtask

    task automatic apply_reset(input logic ign_during_reset);
        reset = 1'b1;
        brk_raw = 1'b0; ignition_raw = ign_during_reset; hidden_sw_raw = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("outputs_in_reset", dut_vec(), 7'b0);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic b, i, h;
        int   cycles;
        logic exp_b, exp_i, exp_h;
    } phase_t;

    phase_t phases [16];

    initial begin
        // Glitch, chatter and simultaneous-return phases
        phases[0]  = '{1, 0, 0, 3,  0, 0, 0};
        phases[1]  = '{0, 0, 0, 8,  0, 0, 0};
        for (int k = 0; k < 10; k++) begin
            phases[2 + k] = '{0, 0, (k % 2 == 0) ? 1'b1 : 1'b0, 2, 0, 0, 0};
        end
        phases[12] = '{0, 0, 1, 10, 0, 0, 1};
        phases[13] = '{0, 0, 0, 10, 0, 0, 0};
        phases[14] = '{1, 0, 1, 10, 1, 0, 1};
        phases[15] = '{0, 0, 0, 10, 0, 0, 0};

        apply_reset(1'b0);

        // Startup: ready after edge 7, no pulses
        for (int e = 1; e <= 10; e++) begin
            cycle(0, 0, 0);
            check("startup_ready", ready, (e >= 7));
            check("startup_levels", {brk, ignition, hidden_sw, any_change}, 4'b0);
        end

        // Ignition on, then off
        for (int e = 1; e <= 8; e++) begin
            cycle(0, 1, 0);
            check("ign_on_level", ignition, (e >= 6));
            check("ign_rise", ignition_rise, (e == 6));
            check("ign_on_any", any_change, (e == 6));
        end
        for (int e = 1; e <= 8; e++) begin
            cycle(0, 0, 0);
            check("ign_off_level", ignition, (e < 6));
            check("ign_fall", ignition_fall, (e == 6));
        end

        // Four-cycle brake pulse just survives the filter
        for (int e = 1; e <= 12; e++) begin
            cycle((e <= 4), 0, 0);
            check("brk_pulse4", brk, (e >= 6 && e < 10));
            check("brk_pulse4_any", any_change, (e == 6 || e == 10));
        end

        // Table-driven phases
        for (int p = 0; p < 16; p++) begin
            for (int n = 0; n < phases[p].cycles; n++) begin
                cycle(phases[p].b, phases[p].i, phases[p].h);
            end
            check("phase_levels", {brk, ignition, hidden_sw},
                  {phases[p].exp_b, phases[p].exp_i, phases[p].exp_h});
        end

        // Simultaneous rise on all channels
        for (int e = 1; e <= 8; e++) begin
            cycle(1, 1, 1);
            check("simul_levels", {brk, ignition, hidden_sw}, (e >= 6) ? 3'b111 : 3'b000);
            check("simul_any", any_change, (e == 6));
        end

        // Start dropping all inputs, then reset while counters hold 2
        for (int e = 1; e <= 4; e++) cycle(0, 0, 0);
        check("pre_reset_levels", {brk, ignition, hidden_sw, ready}, 4'b1111);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_clear", dut_vec(), 7'b0);
        apply_reset(1'b0);
        for (int e = 1; e <= 10; e++) begin
            cycle(0, 0, 0);
            check("restart_ready", ready, (e >= 7));
            check("restart_levels", {brk, ignition, hidden_sw, any_change}, 4'b0);
        end

        // Ignition already on across reset release
        apply_reset(1'b1);
        for (int e = 1; e <= 10; e++) begin
            cycle(0, 1, 0);
            check("hot_ign_level", ignition, (e >= 6));
            check("hot_ready", ready, (e >= 7));
            check("hot_no_pulse", {ignition_rise, any_change}, 2'b00);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
